// File: rtl/quad_decoder.sv
// Quadrature encoder front end: two-flop synchronizer, per-bit debounce, and a
// step decoder driving a 5-bit position count. A = pmod[1], B = pmod[0].
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_INIT | filtered bits track the synchronizer; DEB_CYCLES+2 clocks
//   ST_RUN  | debounce active; filtered transitions decoded into steps
module quad_decoder #(
   parameter int DEB_CYCLES = 16,
   parameter bit WRAP       = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] pmod,
   input  logic       clr,
   output logic [4:0] led,
   output logic       dir,
   output logic       step,
   output logic       err
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   localparam logic [8:0] INIT_LOAD = 9'(DEB_CYCLES + 1);
   localparam logic [7:0] STAB_LAST = 8'(DEB_CYCLES - 1);

   state_t          state_q, state_d;
   logic [8:0]      init_cnt_q, init_cnt_d;
   logic [1:0]      sync1_q, sync1_d;
   logic [1:0]      sync2_q, sync2_d;
   logic [1:0]      filt_q, filt_d;
   logic [1:0]      prev_q, prev_d;
   logic [1:0][7:0] stab_q, stab_d;
   logic [4:0]      led_q, led_d;
   logic            dir_q, dir_d;
   logic            step_q, step_d;
   logic            err_q, err_d;
   logic [1:0]      chg;
   logic            up;

   always_comb begin
      sync1_d    = pmod;
      sync2_d    = sync1_q;
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      filt_d     = filt_q;
      prev_d     = filt_q;
      stab_d     = stab_q;
      led_d      = led_q;
      dir_d      = dir_q;
      step_d     = 1'b0;
      err_d      = err_q;
      chg        = filt_q ^ prev_q;
      up         = prev_q[1] ^ filt_q[0];

      case (state_q)
         ST_INIT: begin
            filt_d = sync2_q;
            prev_d = sync2_q;
            stab_d = '0;
            if (init_cnt_q == 9'd0) state_d = ST_RUN;
            else                    init_cnt_d = init_cnt_q - 9'd1;
         end
         default: begin
            for (int i = 0; i < 2; i++) begin
               if (sync2_q[i] != filt_q[i]) begin
                  if (stab_q[i] == STAB_LAST) begin
                     filt_d[i] = sync2_q[i];
                     stab_d[i] = 8'd0;
                  end else begin
                     stab_d[i] = stab_q[i] + 8'd1;
                  end
               end else begin
                  stab_d[i] = 8'd0;
               end
            end

            // Gray code: exactly one bit changing is a step, both is illegal.
            if (chg == 2'b11) begin
               err_d = 1'b1;
            end else if (chg != 2'b00) begin
               dir_d  = up;
               step_d = 1'b1;
               if (up) begin
                  if (led_q != 5'd31)  led_d = led_q + 5'd1;
                  else if (WRAP)       led_d = 5'd0;
               end else begin
                  if (led_q != 5'd0)   led_d = led_q - 5'd1;
                  else if (WRAP)       led_d = 5'd31;
               end
            end
         end
      endcase

      if (clr) begin
         led_d  = 5'd0;
         err_d  = 1'b0;
         step_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_INIT;
         init_cnt_q <= INIT_LOAD;
         sync1_q    <= 2'b00;
         sync2_q    <= 2'b00;
         filt_q     <= 2'b00;
         prev_q     <= 2'b00;
         stab_q     <= '0;
         led_q      <= 5'd0;
         dir_q      <= 1'b1;
         step_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         filt_q     <= filt_d;
         prev_q     <= prev_d;
         stab_q     <= stab_d;
         led_q      <= led_d;
         dir_q      <= dir_d;
         step_q     <= step_d;
         err_q      <= err_d;
      end
   end

   assign led  = led_q;
   assign dir  = dir_q;
   assign step = step_q;
   assign err  = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder with DEB_CYCLES=4; a wrapping and a
// saturating instance share the same stimulus.
module tb_quad_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       clr;
   logic [1:0] pmod;
   logic [4:0] led_w, led_s;
   logic       dir_w, dir_s, step_w, step_s, err_w, err_s;

   int n_tests = 0;
   int n_fail  = 0;
   int nstep_w = 0;
   int nstep_s = 0;
   int base_w, base_s, lat;

   always #5 clk = ~clk;

   quad_decoder #(.DEB_CYCLES(4), .WRAP(1'b1)) dut_w (
      .clk(clk), .rst(rst), .pmod(pmod), .clr(clr),
      .led(led_w), .dir(dir_w), .step(step_w), .err(err_w)
   );

   quad_decoder #(.DEB_CYCLES(4), .WRAP(1'b0)) dut_s (
      .clk(clk), .rst(rst), .pmod(pmod), .clr(clr),
      .led(led_s), .dir(dir_s), .step(step_s), .err(err_s)
   );

   always @(negedge clk) begin
      if (step_w) nstep_w++;
      if (step_s) nstep_s++;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clocks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive a new pmod value, hold it for 'hold' clocks, and report how many
   // clocks passed until led_w changed (-1 if it never did).
   task automatic edge_to(input logic [1:0] v, input int hold, output int l);
      logic [4:0] old;
      old = led_w;
      l = -1;
      pmod = v;
      for (int i = 1; i <= hold; i++) begin
         @(posedge clk);
         #1;
         if (l < 0 && led_w != old) l = i;
      end
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      clocks(1);
      clr = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_led_w"}, led_w, 0);
      check({tag, "_dir_w"}, dir_w, 1);
      check({tag, "_step_w"}, step_w, 0);
      check({tag, "_err_w"}, err_w, 0);
      check({tag, "_led_s"}, led_s, 0);
      check({tag, "_dir_s"}, dir_s, 1);
   endtask

   logic [1:0] walk [4];

   initial begin
      walk[0] = 2'b01; walk[1] = 2'b11; walk[2] = 2'b10; walk[3] = 2'b00;
      rst = 1'b1; clr = 1'b0; pmod = 2'b11;
      @(posedge clk);
      clocks(3);
      check_reset_vals("rst_hold");

      // nonzero resting phase through INIT: no step, no err
      rst = 1'b0;
      base_w = nstep_w;
      clocks(20);
      check("init11_led", led_w, 0);
      check("init11_steps", nstep_w - base_w, 0);
      check("init11_err", err_w, 0);

      rst = 1'b1; pmod = 2'b00;
      clocks(2);
      rst = 1'b0;
      clocks(20);

      // up walk: each update 2+4+1 clocks after the pmod edge
      base_w = nstep_w; base_s = nstep_s;
      for (int k = 0; k < 4; k++) begin
         edge_to(walk[k], 10, lat);
         check($sformatf("up%0d_lat", k), lat, 7);
         check($sformatf("up%0d_led_w", k), led_w, k + 1);
         check($sformatf("up%0d_led_s", k), led_s, k + 1);
         check($sformatf("up%0d_dir", k), dir_w, 1);
      end
      check("up_steps_w", nstep_w - base_w, 4);
      check("up_steps_s", nstep_s - base_s, 4);

      pulse_clr();
      check("clr_led_w", led_w, 0);
      check("clr_led_s", led_s, 0);

      // down from 0: wrap to 31 vs saturate at 0
      base_w = nstep_w; base_s = nstep_s;
      edge_to(2'b10, 10, lat);
      check("dn_lat", lat, 7);
      check("dn_led_w", led_w, 31);
      check("dn_led_s", led_s, 0);
      check("dn_dir_w", dir_w, 0);
      check("dn_dir_s", dir_s, 0);
      check("dn_steps_w", nstep_w - base_w, 1);
      check("dn_steps_s", nstep_s - base_s, 1);

      edge_to(2'b00, 10, lat);
      check("upwrap_led_w", led_w, 0);
      check("upwrap_led_s", led_s, 1);
      check("upwrap_dir_w", dir_w, 1);

      // short glitches on A never make it through the filter
      base_w = nstep_w; base_s = nstep_s;
      for (int k = 0; k < 5; k++) begin
         pmod = 2'b10; clocks(3);
         pmod = 2'b00; clocks(3);
      end
      clocks(10);
      check("glitch_led_w", led_w, 0);
      check("glitch_led_s", led_s, 1);
      check("glitch_steps", nstep_w - base_w, 0);

      // both bits at once: illegal, sticky err
      base_w = nstep_w;
      pmod = 2'b11;
      clocks(10);
      check("ill_err_w", err_w, 1);
      check("ill_err_s", err_s, 1);
      check("ill_led_w", led_w, 0);
      check("ill_led_s", led_s, 1);
      check("ill_dir_w", dir_w, 1);
      check("ill_steps", nstep_w - base_w, 0);
      clocks(10);
      check("ill_sticky", err_w, 1);
      pulse_clr();
      check("ill_clr_err_w", err_w, 0);
      check("ill_clr_err_s", err_s, 0);
      check("ill_clr_led_s", led_s, 0);

      // 11 -> 01 is a down step
      edge_to(2'b01, 10, lat);
      check("dn2_led_w", led_w, 31);
      check("dn2_dir_w", dir_w, 0);

      // reset 2 clocks into the debounce of 01 -> 00
      base_w = nstep_w; base_s = nstep_s;
      pmod = 2'b00;
      clocks(2);
      rst = 1'b1;
      clocks(1);
      check_reset_vals("rst_mid");
      rst = 1'b0;
      clocks(20);
      check("post_rst_steps_w", nstep_w - base_w, 0);
      check("post_rst_steps_s", nstep_s - base_s, 0);
      check("post_rst_led", led_w, 0);
      check("post_rst_dir", dir_w, 1);
      check("post_rst_err", err_w, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 16: consecutive stable clocks required before a filtered input bit changes (legal range 2..255).
REQ-002 SHALL have parameter WRAP, default 1: 1 = count wraps modulo 32; 0 = count saturates at 0 and 31.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous reset, active-high.
REQ-005 SHALL have port pmod, input, 2: asynchronous quadrature encoder pins; A = pmod[1], B = pmod[0].
REQ-006 SHALL have port clr, input, 1: synchronous clear of count and err; no other state affected.
REQ-007 SHALL have port led, output, 5: position count, registered.
REQ-008 SHALL have port dir, output, 1: direction of last accepted step; 1 = up, 0 = down.
REQ-009 SHALL have port step, output, 1: one-clock pulse per accepted step.
REQ-010 SHALL have port err, output, 1: sticky illegal-transition flag.

Function
REQ-011 SHALL pass each pmod bit through a two-flop synchronizer before any other use.
REQ-012 SHALL debounce A and B independently: a filtered bit takes the synchronized value only after that value has differed from the filtered bit for DEB_CYCLES consecutive clocks; any return to equality restarts its stability counter at 0.
REQ-013 SHALL run a two-state controller: INIT and RUN.
REQ-014 INIT: SHALL last exactly DEB_CYCLES+2 clocks after reset release; filtered bits load the synchronized values directly every clock; no count, step or err activity.
REQ-015 INIT -> RUN: SHALL be unconditional at the end of the INIT interval; the filtered pair at that moment is the reference phase.
REQ-016 RUN: SHALL compare the filtered pair (AB) with its value in the previous clock every clock.
REQ-017 Up sequence SHALL be 00->01->11->10->00; each such single-bit change is one up step.
REQ-018 Down sequence SHALL be the reverse, 00->10->11->01->00; each is one down step.
REQ-019 On a legal step, the clock after the filtered change SHALL update led by +1 (up) or -1 (down), set dir to the step direction, and assert step for exactly one clock.
REQ-020 Both filtered bits changing in the same clock SHALL be illegal: led and dir unchanged, no step, err set to 1 and held.
REQ-021 No filtered change SHALL produce no led/dir change and step = 0.
REQ-022 WRAP=1: up from 31 SHALL give 0; down from 0 SHALL give 31; step still pulses.
REQ-023 WRAP=0: up at 31 or down at 0 SHALL leave led unchanged, still update dir and pulse step.
REQ-024 Latency from a clean pmod edge to the led update SHALL be 2 (synchronizer) + DEB_CYCLES + 1 clocks.
REQ-025 clr=1 SHALL force led=0 and err=0 next clock; a step coinciding with clr SHALL be discarded (clr wins); dir and step behave as without clr except that step is 0 on a discarded step.
REQ-026 A step accepted in the same clock err is set SHALL NOT occur (REQ-020 excludes it).

Reset
REQ-027 rst=1 SHALL on the next clock set: led=0, dir=1, step=0, err=0, synchronizers=0, filtered bits=0, stability counters=0, state=INIT.
REQ-028 rst SHALL take priority over clr and all other activity, including assertion mid-debounce or mid-step; a partially debounced change is discarded.
REQ-029 After rst deasserts, REQ-014/015 SHALL apply regardless of pmod level (no spurious step or err from a nonzero resting phase).

Verification (DEB_CYCLES=4)
REQ-030 Reset with pmod=11 held, run 20 clocks -> led=0, step never 1, err=0, state RUN.
REQ-031 From AB=00 in RUN, drive 01,11,10,00 each held 10 clocks -> four step pulses, led 0->4, dir=1, each update 7 clocks after its pmod edge.
REQ-032 From led=0, drive one down step (00->10), WRAP=1 -> led=31, dir=0; repeat with WRAP=0 -> led stays 0, step pulses once.
REQ-033 Toggle A for 3 clocks then return, repeated 5 times -> no filtered change, led unchanged, step=0.
REQ-034 Change pmod 00->11 in one clock, hold 10 clocks -> err=1 and stays 1, led unchanged; then clr=1 one clock -> led=0, err=0.
REQ-035 Assert rst mid-debounce (2 clocks after a legal edge) -> outputs at reset values, no step after release.
